// File: rtl/ps2_arcade_keymap_pkg.sv
// MCR1 keyboard-to-arcade button map.
// Button bit indices, scan codes and the decode helper.
package mcr_keys_pkg;

  localparam int BTN_W = 18;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_FIREA  = 4;
  localparam int BTN_FIREB  = 5;
  localparam int BTN_FIREC  = 6;
  localparam int BTN_START1 = 7;
  localparam int BTN_START2 = 8;
  localparam int BTN_COIN1  = 9;
  localparam int BTN_COIN2  = 10;
  localparam int BTN_UP2    = 11;
  localparam int BTN_DOWN2  = 12;
  localparam int BTN_LEFT2  = 13;
  localparam int BTN_RIGHT2 = 14;
  localparam int BTN_FIRE2A = 15;
  localparam int BTN_FIRE2B = 16;
  localparam int BTN_TILT   = 17;

  // P2 third fire has no slot of its own in the
  // 18-bit vector; it shares the second P2 fire bit.
  localparam int BTN_FIRE2C = BTN_FIRE2B;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_FIREA  = 8'h14;
  localparam logic [7:0] SC_FIREB  = 8'h11;
  localparam logic [7:0] SC_FIREC  = 8'h29;
  localparam logic [7:0] SC_START1 = 8'h05;
  localparam logic [7:0] SC_1      = 8'h16;
  localparam logic [7:0] SC_START2 = 8'h06;
  localparam logic [7:0] SC_2      = 8'h1E;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_COIN1  = 8'h76;
  localparam logic [7:0] SC_5      = 8'h2E;
  localparam logic [7:0] SC_COIN2  = 8'h36;
  localparam logic [7:0] SC_UP2    = 8'h2D;
  localparam logic [7:0] SC_DOWN2  = 8'h2B;
  localparam logic [7:0] SC_LEFT2  = 8'h23;
  localparam logic [7:0] SC_RIGHT2 = 8'h34;
  localparam logic [7:0] SC_FIRE2A = 8'h1C;
  localparam logic [7:0] SC_FIRE2B = 8'h1B;
  localparam logic [7:0] SC_FIRE2C = 8'h15;
  localparam logic [7:0] SC_TILT   = 8'h0D;

  typedef logic [BTN_W-1:0] btn_t;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_ev_t;

  function automatic btn_t bit_mask(input int idx);
    btn_t m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // One-hot button mask for a scan code, zero when unmapped.
  function automatic btn_t key_map(input logic ext,
                                   input logic [7:0] code);
    btn_t m;
    m = '0;
    unique case (code)
      SC_UP:     m = bit_mask(BTN_UP);
      SC_DOWN:   m = bit_mask(BTN_DOWN);
      SC_LEFT:   m = bit_mask(BTN_LEFT);
      SC_RIGHT:  m = bit_mask(BTN_RIGHT);
      SC_FIREA:  m = bit_mask(BTN_FIREA);
      SC_FIREB:  m = bit_mask(BTN_FIREB);
      SC_FIREC:  m = bit_mask(BTN_FIREC);
      SC_START1: m = bit_mask(BTN_START1);
      SC_1:      m = bit_mask(BTN_START1);
      SC_START2: m = bit_mask(BTN_START2);
      SC_2:      m = bit_mask(BTN_START2);
      SC_ENTER:  m = ext ? bit_mask(BTN_START2)
                         : bit_mask(BTN_START1);
      SC_COIN1:  m = bit_mask(BTN_COIN1);
      SC_5:      m = bit_mask(BTN_COIN1);
      SC_COIN2:  m = bit_mask(BTN_COIN2);
      SC_UP2:    m = bit_mask(BTN_UP2);
      SC_DOWN2:  m = bit_mask(BTN_DOWN2);
      SC_LEFT2:  m = bit_mask(BTN_LEFT2);
      SC_RIGHT2: m = bit_mask(BTN_RIGHT2);
      SC_FIRE2A: m = bit_mask(BTN_FIRE2A);
      SC_FIRE2B: m = bit_mask(BTN_FIRE2B);
      SC_FIRE2C: m = bit_mask(BTN_FIRE2C);
      SC_TILT:   m = bit_mask(BTN_TILT);
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_arcade_keymap_if.sv
// Keyboard/video side bundle of the arcade keymap.
// master drives ps2_key/vs/clear, slave returns btn.
interface ps2_arcade_keymap_if;
  import mcr_keys_pkg::*;

  logic [10:0] ps2_key;
  logic        vs;
  logic        clear;
  btn_t        btn;
  logic        key_event;

  modport master (
    output ps2_key,
    output vs,
    output clear,
    input  btn,
    input  key_event
  );

  modport slave (
    input  ps2_key,
    input  vs,
    input  clear,
    output btn,
    output key_event
  );

endinterface

// File: rtl/ps2_arcade_keymap_coin_stretch.sv
// Coin pulse stretcher: a press keeps the coin line
// high for at least COIN_FRAMES frame ticks.
module coin_stretch #(
  parameter int COIN_FRAMES = 3,
  parameter int CNT_W       = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic press_ev,
  input  logic held,
  input  logic tick,
  output logic out
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(COIN_FRAMES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy;

  assign busy = (cnt_q != '0);

  // Load on press, count down on frame ticks.
  always_comb begin
    cnt_d = cnt_q;
    if (press_ev)
      cnt_d = LOAD;
    else if (tick && busy)
      cnt_d = cnt_q - 1'b1;
  end

  // Frame counter register.
  always_ff @(posedge clk_sys) begin
    if (reset || clear)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign out = held | busy;

endmodule

// File: rtl/ps2_arcade_keymap.sv
// PS/2 make/break decoder to held arcade buttons
// with frame-stretched coin outputs.
module ps2_arcade_keymap
  import mcr_keys_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int CNT_W       = 4
) (
  input logic                clk_sys,
  input logic                reset,
  ps2_arcade_keymap_if.slave bus
);

  ps2_ev_t ev_in;
  logic    tog_q;
  logic    vs_d;
  logic    ev;
  logic    mapped;
  logic    vs_rise;
  btn_t    mask;
  btn_t    held_q;
  btn_t    held_d;
  logic    key_event_q;
  logic    coin1_press;
  logic    coin2_press;
  logic    coin1_out;
  logic    coin2_out;
  btn_t    btn_c;

  assign ev_in   = ps2_ev_t'(bus.ps2_key);
  assign ev      = ev_in.toggle ^ tog_q;
  assign mask    = key_map(ev_in.ext, ev_in.code);
  assign mapped  = |mask;
  assign vs_rise = bus.vs & ~vs_d;

  // Toggle tracker and vsync delay follow inputs every cycle.
  always_ff @(posedge clk_sys) begin
    tog_q <= ev_in.toggle;
    vs_d  <= bus.vs;
  end

  // Apply an accepted event to the held key set.
  always_comb begin
    held_d = held_q;
    if (ev && mapped) begin
      if (ev_in.pressed)
        held_d = held_q | mask;
      else
        held_d = held_q & ~mask;
    end
  end

  // Held keys and event pulse; clear drops everything.
  always_ff @(posedge clk_sys) begin
    if (reset || bus.clear) begin
      held_q      <= '0;
      key_event_q <= 1'b0;
    end else begin
      held_q      <= held_d;
      key_event_q <= ev & mapped;
    end
  end

  assign coin1_press = ev & ev_in.pressed & mask[BTN_COIN1];
  assign coin2_press = ev & ev_in.pressed & mask[BTN_COIN2];

  coin_stretch #(
    .COIN_FRAMES (COIN_FRAMES),
    .CNT_W       (CNT_W)
  ) u_coin1 (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clear    (bus.clear),
    .press_ev (coin1_press),
    .held     (held_q[BTN_COIN1]),
    .tick     (vs_rise),
    .out      (coin1_out)
  );

  coin_stretch #(
    .COIN_FRAMES (COIN_FRAMES),
    .CNT_W       (CNT_W)
  ) u_coin2 (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clear    (bus.clear),
    .press_ev (coin2_press),
    .held     (held_q[BTN_COIN2]),
    .tick     (vs_rise),
    .out      (coin2_out)
  );

  // Coin bits come from the stretchers, the rest as held.
  always_comb begin
    btn_c            = held_q;
    btn_c[BTN_COIN1] = coin1_out;
    btn_c[BTN_COIN2] = coin2_out;
  end

  assign bus.btn       = btn_c;
  assign bus.key_event = key_event_q;

endmodule

// File: tb/tb_ps2_arcade_keymap.sv
// Directed bench for ps2_arcade_keymap.
// Linear steps with immediate assertions.
module tb_ps2_arcade_keymap;
  import mcr_keys_pkg::*;

  logic clk_sys;
  logic reset;
  int   vectors;
  int   miscompares;
  logic bad;

  ps2_arcade_keymap_if bus ();

  ps2_arcade_keymap #(
    .COIN_FRAMES (3),
    .CNT_W       (4)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic p, input logic e,
                      input logic [7:0] c);
    bus.ps2_key = {~bus.ps2_key[10], p, e, c};
    step();
  endtask

  task automatic tick();
    bus.vs = 1'b1;
    step();
    bus.vs = 1'b0;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.ps2_key = 11'h400;
    bus.vs      = 1'b0;
    bus.clear   = 1'b0;
    step();
    step();
    chk("reset_btn", 32'(bus.btn), 32'h0);
    chk("reset_kev", 32'(bus.key_event), 32'h0);
    reset = 1'b0;

    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.btn !== '0 || bus.key_event !== 1'b0)
        bad = 1'b1;
    end
    chk("idle_100", 32'(bad), 32'h0);

    send(1'b1, 1'b0, 8'h14);
    chk("fireA_kev", 32'(bus.key_event), 32'h1);
    chk("fireA_on", 32'(bus.btn), 32'h00010);
    step();
    chk("kev_pulse", 32'(bus.key_event), 32'h0);
    send(1'b0, 1'b0, 8'h14);
    chk("fireA_off", 32'(bus.btn), 32'h00000);

    send(1'b1, 1'b0, 8'h6B);
    chk("left_on", 32'(bus.btn), 32'h00004);
    send(1'b0, 1'b0, 8'h6B);
    chk("left_off", 32'(bus.btn), 32'h00000);

    send(1'b1, 1'b0, 8'h2E);
    chk("coin1_on", 32'(bus.btn), 32'h00200);
    for (int i = 0; i < 9; i++) step();
    send(1'b0, 1'b0, 8'h2E);
    chk("coin1_rel", 32'(bus.btn), 32'h00200);
    tick();
    chk("coin1_t1", 32'(bus.btn), 32'h00200);
    tick();
    chk("coin1_t2", 32'(bus.btn), 32'h00200);
    bus.vs = 1'b1;
    step();
    chk("coin1_t3", 32'(bus.btn), 32'h00000);
    bus.vs = 1'b0;
    step();

    send(1'b1, 1'b0, 8'h36);
    send(1'b0, 1'b0, 8'h36);
    tick();
    tick();
    chk("coin2_cnt1", 32'(bus.btn), 32'h00400);
    bus.ps2_key = {~bus.ps2_key[10], 1'b1, 1'b0, 8'h36};
    bus.vs      = 1'b1;
    step();
    bus.vs = 1'b0;
    chk("coin2_ld_kev", 32'(bus.key_event), 32'h1);
    send(1'b0, 1'b0, 8'h36);
    chk("coin2_reload", 32'(bus.btn), 32'h00400);
    tick();
    tick();
    chk("coin2_r2", 32'(bus.btn), 32'h00400);
    tick();
    chk("coin2_done", 32'(bus.btn), 32'h00000);

    send(1'b1, 1'b0, 8'h75);
    send(1'b1, 1'b0, 8'h1C);
    chk("up_f2a", 32'(bus.btn), 32'h08001);
    bus.clear   = 1'b1;
    bus.ps2_key = {~bus.ps2_key[10], 1'b1, 1'b0, 8'h14};
    step();
    bus.clear = 1'b0;
    chk("clear_btn", 32'(bus.btn), 32'h00000);
    chk("clear_kev", 32'(bus.key_event), 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.btn !== '0 || bus.key_event !== 1'b0)
        bad = 1'b1;
    end
    chk("no_replay", 32'(bad), 32'h0);

    send(1'b1, 1'b1, 8'h5A);
    chk("kp_enter", 32'(bus.btn), 32'h00100);
    chk("kp_ent_kev", 32'(bus.key_event), 32'h1);

    send(1'b1, 1'b0, 8'h4A);
    chk("unmap_kev", 32'(bus.key_event), 32'h0);
    chk("unmap_btn", 32'(bus.btn), 32'h00100);

    send(1'b1, 1'b0, 8'h5A);
    chk("enter_s1", 32'(bus.btn), 32'h00180);
    send(1'b1, 1'b0, 8'h05);
    send(1'b0, 1'b0, 8'h16);
    chk("alias_rel", 32'(bus.btn), 32'h00100);
    send(1'b1, 1'b0, 8'h0D);
    chk("tilt", 32'(bus.btn), 32'h20100);

    send(1'b1, 1'b0, 8'h76);
    send(1'b0, 1'b0, 8'h76);
    chk("coin1_mid", 32'(bus.btn), 32'h20300);
    reset = 1'b1;
    step();
    chk("rst_mid", 32'(bus.btn), 32'h00000);
    reset = 1'b0;
    step();
    chk("rst_after", 32'(bus.btn), 32'h00000);
    chk("rst_kev", 32'(bus.key_event), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_arcade_keymap.md
Name: ps2_arcade_keymap

Overview:
- Sits between `hps_io`'s `ps2_key` toggle interface and the per-game `input_0`..`input_4` assembly in the MCR1 top level.
- Decodes make/break events into a held two-player arcade button vector.
- Stretches coin presses to a minimum number of video frames so that short key taps are always seen by the game CPU's coin polling.
- Replaces the ad-hoc keyboard `always` block in the core top level.

Parameters:
- COIN_FRAMES, 3: minimum coin-output length in frames (`vs` rising edges); legal 1..15.
- CNT_W, 4: width of each coin frame counter; must hold COIN_FRAMES.

Ports:
- clk_sys  in  1  system clock (40 MHz)
- reset  in  1  synchronous, active-high reset
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scan code
- vs  in  1  video vertical sync from `mcr1`; its rising edge is the frame tick
- clear  in  1  synchronous; releases all held keys (OSD opened, keyboard focus lost)
- btn  out  18  held button vector; bit indices defined in the package
- key_event  out  1  one-cycle pulse per accepted (mapped) event

Behaviour:
- Reset: btn=0, key_event=0, both coin counters=0. The toggle tracker loads the current ps2_key[10], so no spurious event follows reset release.
- Event detect: an event occurs when ps2_key[10] differs from the tracker. The tracker updates every cycle.
- Mapped key: btn bit <= ps2_key[9] on the same clock edge (1-cycle latency from the toggle change). key_event pulses on that edge.
- Unmapped codes: ignored; key_event stays 0.
- Key map (ext bit ignored unless stated):
  - P1 directions: 75 up, 72 down, 6B left, 74 right.
  - P1 fires: 14 fireA, 11 fireB, 29 fireC.
  - Starts: 05/16 start1, 06/1E start2; 5A with ext=1 (keypad Enter) start2, 5A with ext=0 start1.
  - Coins: 76/2E coin1, 36 coin2.
  - P2 directions: 2D up2, 2B down2, 23 left2, 34 right2.
  - P2 fires: 1C fire2A, 1B fire2B, 15 fire2C.
  - 0D tilt.
  - Aliased codes OR into a single held bit; the last event wins (press sets, release clears).
- Frame tick: vs_rise = vs & ~vs_d, using a one-register delay.
- Coin stretch (per coin, independent):
  - Press event loads counter with COIN_FRAMES.
  - vs_rise with counter != 0 decrements by 1.
  - Press and vs_rise on the same cycle: load wins.
  - Coin output = key_held | (counter != 0).
  - Release before expiry: output stays high until counter reaches 0.
  - Repeated press while counting: reloads the counter (no accumulation, no wrap).
- clear: zeros all held bits and both counters on that edge, overriding any simultaneous event. The toggle tracker still updates, so the consumed event is not replayed.
- reset mid-stretch: counter and output drop to 0 on the reset edge.
- btn is fully registered; there is no combinational path from ps2_key to btn.

Decomposition:
- Package `mcr_keys_pkg`:
  - Bit-index localparams BTN_UP..BTN_TILT (0..17).
  - Scan-code localparams.
  - BTN_W = 18.
- Sub-module `coin_stretch`, instantiated twice:
  - Inputs: clk_sys, reset, clear, press_ev, held, tick.
  - Output: out.
  - Parameters: COIN_FRAMES, CNT_W.

Test Plan:
- Reset with ps2_key[10]=1, then release reset with no toggle -> btn=0 and key_event=0 for 100 cycles.
- Toggle with {pressed=1, code=14} -> btn[BTN_FIREA]=1 and key_event=1 one cycle later. Toggle with {pressed=0, code=14} -> bit 0.
- Coin tap: press 2E, release 2E 10 cycles later, COIN_FRAMES=3 -> coin1 stays high through 3 vs rising edges and drops in the cycle after the third.
- Press 36 on the same cycle as a vs rising edge while the coin2 counter=1 -> counter=3, coin2 held.
- Hold 75 and 1C, assert clear for 1 cycle -> btn=0, and no reassertion without a new event. Toggle with code 5A, ext=1, pressed=1 -> start2=1, start1=0.
- Toggle with unmapped code 4A -> btn unchanged, key_event=0. Assert reset during a coin stretch -> coin1=0 on the next edge.
